// File: rtl/tick_generator_if.sv
// Control/strobe bundle between the tick generator and whatever drives it
// (switches, push button) and consumes it (display counter, LED).
interface tick_generator_if;
    logic       enable;
    logic [1:0] sel;
    logic       step_n;
    logic       tick;
    logic       heartbeat;

    modport master (output enable, sel, step_n, input tick, heartbeat);
    modport slave  (input enable, sel, step_n, output tick, heartbeat);
endinterface

// File: rtl/tick_generator.sv
// Divides clk into a one-cycle tick strobe at 1, 1/CLK_HZ, 1/(2*CLK_HZ) or
// 1/(4*CLK_HZ) of the clock rate, with pause and push-button single step.
module tick_generator #(
    parameter int CLK_HZ = 50_000_000,
    parameter int CW     = 28          // 2**CW must exceed 4*CLK_HZ
) (
    input  logic            clk,
    input  logic            clr,
    tick_generator_if.slave bus
);

    localparam logic [CW-1:0] RELOAD_00 = '0;
    localparam logic [CW-1:0] RELOAD_01 = CW'(CLK_HZ - 1);
    localparam logic [CW-1:0] RELOAD_10 = CW'(2 * CLK_HZ - 1);
    localparam logic [CW-1:0] RELOAD_11 = CW'(4 * CLK_HZ - 1);

    function automatic logic [CW-1:0] reload_of(input logic [1:0] s);
        reload_of = RELOAD_00;
        case (s)
            2'b00: reload_of = RELOAD_00;
            2'b01: reload_of = RELOAD_01;
            2'b10: reload_of = RELOAD_10;
            2'b11: reload_of = RELOAD_11;
            default: reload_of = RELOAD_00;
        endcase
    endfunction

    logic [CW-1:0] r_count;
    logic [1:0]    r_sel_q;
    logic          r_s1, r_s2, r_s3;
    logic          r_tick;
    logic          r_heartbeat;

    logic [CW-1:0] w_count_nxt;
    logic [1:0]    w_sel_q_nxt;
    logic          w_tick_nxt;
    logic          w_heartbeat_nxt;
    logic          w_press;

    // r_s1/r_s2 resynchronise the raw button; r_s3 detects its falling edge.
    assign w_press = r_s3 & ~r_s2;

    always_comb begin
        // NOTE: every output of this block gets a default first so no path can
        // leave one unassigned and infer a latch.
        w_count_nxt = r_count;
        w_sel_q_nxt = r_sel_q;
        w_tick_nxt  = 1'b0;

        if (bus.sel != r_sel_q) begin
            w_sel_q_nxt = bus.sel;
            w_count_nxt = reload_of(bus.sel);
        end else if (bus.enable) begin
            if (r_count == '0) begin
                w_tick_nxt  = 1'b1;
                w_count_nxt = reload_of(r_sel_q);
            end else begin
                w_count_nxt = r_count - CW'(1);
            end
        end else begin
            w_tick_nxt = w_press;
        end

        w_heartbeat_nxt = r_heartbeat ^ w_tick_nxt;
    end

    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            r_count     <= '0;
            r_sel_q     <= 2'b00;
            r_s1        <= 1'b1;
            r_s2        <= 1'b1;
            r_s3        <= 1'b1;
            r_tick      <= 1'b0;
            r_heartbeat <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so the s1->s2->s3 chain shifts by
            // one stage per edge regardless of statement order.
            r_count     <= w_count_nxt;
            r_sel_q     <= w_sel_q_nxt;
            r_s1        <= bus.step_n;
            r_s2        <= r_s1;
            r_s3        <= r_s2;
            r_tick      <= w_tick_nxt;
            r_heartbeat <= w_heartbeat_nxt;
        end
    end

    assign bus.tick      = r_tick;
    assign bus.heartbeat = r_heartbeat;

endmodule

// File: tb/tb_tick_generator.sv
// Directed bench for tick_generator with CLK_HZ = 4, CW = 5
// (reload values 0, 3, 7, 15 for sel 00, 01, 10, 11).
module tb_tick_generator;

    logic clk;
    logic clr;
    int   n_tests;
    int   n_fail;
    logic hb_exp;

    tick_generator_if bus ();

    tick_generator #(.CLK_HZ(4), .CW(5)) dut (
        .clk (clk),
        .clr (clr),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic next_edge;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        clr = 1'b0;
        bus.enable = 1'b0;
        bus.sel    = 2'b00;
        bus.step_n = 1'b1;
        hb_exp     = 1'b0;
        #2;
        n_tests++;
        if (bus.tick !== 1'b0) begin
            n_fail++; $display("FAIL reset_tick: got %0b want 0", bus.tick);
        end
        n_tests++;
        if (bus.heartbeat !== 1'b0) begin
            n_fail++; $display("FAIL reset_hb: got %0b want 0", bus.heartbeat);
        end
        n_tests++;
        if (dut.r_count !== 5'd0) begin
            n_fail++; $display("FAIL reset_count: got %0d want 0", dut.r_count);
        end
    endtask

    // Asserts clr between edges, checks the asynchronous clear, then runs rate 01.
    task automatic test_rate01(input string tag);
        logic exp_tick;
        #2;
        clr        = 1'b0;
        bus.enable = 1'b1;
        bus.sel    = 2'b01;
        bus.step_n = 1'b1;
        hb_exp     = 1'b0;
        #1;
        n_tests++;
        if (bus.tick !== 1'b0 || bus.heartbeat !== 1'b0 || dut.r_count !== 5'd0) begin
            n_fail++;
            $display("FAIL %s_clr: tick=%0b hb=%0b count=%0d want 0/0/0",
                     tag, bus.tick, bus.heartbeat, dut.r_count);
        end
        @(negedge clk);
        clr = 1'b1;
        for (int k = 1; k <= 13; k++) begin
            next_edge();
            exp_tick = (k == 5 || k == 9 || k == 13);
            hb_exp   = hb_exp ^ exp_tick;
            n_tests++;
            if (bus.tick !== exp_tick || bus.heartbeat !== hb_exp) begin
                n_fail++;
                $display("FAIL %s_edge%0d: tick=%0b hb=%0b want tick=%0b hb=%0b",
                         tag, k, bus.tick, bus.heartbeat, exp_tick, hb_exp);
            end
            if (k == 1) begin
                n_tests++;
                if (dut.r_count !== 5'd3) begin
                    n_fail++;
                    $display("FAIL %s_reload: count=%0d want 3", tag, dut.r_count);
                end
            end
        end
    endtask

    task automatic test_rate_change;
        logic exp_tick;
        for (int k = 14; k <= 54; k++) begin
            @(negedge clk);
            if (k == 15) bus.sel = 2'b11;
            if (k == 48) bus.sel = 2'b00;
            next_edge();
            exp_tick = (k == 31 || k == 47 || k >= 49);
            hb_exp   = hb_exp ^ exp_tick;
            n_tests++;
            if (bus.tick !== exp_tick || bus.heartbeat !== hb_exp) begin
                n_fail++;
                $display("FAIL rate_change_edge%0d: tick=%0b hb=%0b want tick=%0b hb=%0b",
                         k, bus.tick, bus.heartbeat, exp_tick, hb_exp);
            end
            if (k == 15 || k == 48) begin
                n_tests++;
                if (dut.r_count !== ((k == 15) ? 5'd15 : 5'd0)) begin
                    n_fail++;
                    $display("FAIL rate_change_reload%0d: count=%0d", k, dut.r_count);
                end
            end
        end
    endtask

    task automatic test_hold_resume;
        logic exp_tick;
        @(negedge clk);
        bus.sel = 2'b10;
        for (int k = 1; k <= 3; k++) begin
            next_edge();
            n_tests++;
            if (bus.tick !== 1'b0) begin
                n_fail++; $display("FAIL hold_pre_edge%0d: tick=%0b want 0", k, bus.tick);
            end
            if (k < 3) @(negedge clk);
        end
        n_tests++;
        if (dut.r_count !== 5'd5) begin
            n_fail++; $display("FAIL hold_pre_count: count=%0d want 5", dut.r_count);
        end
        @(negedge clk);
        bus.enable = 1'b0;
        for (int k = 1; k <= 20; k++) begin
            next_edge();
            n_tests++;
            if (bus.tick !== 1'b0 || dut.r_count !== 5'd5) begin
                n_fail++;
                $display("FAIL hold_edge%0d: tick=%0b count=%0d want 0/5",
                         k, bus.tick, dut.r_count);
            end
        end
        @(negedge clk);
        bus.enable = 1'b1;
        for (int k = 1; k <= 6; k++) begin
            next_edge();
            exp_tick = (k == 6);
            hb_exp   = hb_exp ^ exp_tick;
            n_tests++;
            if (bus.tick !== exp_tick || bus.heartbeat !== hb_exp) begin
                n_fail++;
                $display("FAIL resume_edge%0d: tick=%0b hb=%0b want tick=%0b hb=%0b",
                         k, bus.tick, bus.heartbeat, exp_tick, hb_exp);
            end
        end
    endtask

    // Button low for samples 1..10 and 14; each press ticks 2 edges later in HOLD.
    task automatic test_single_step;
        logic exp_tick;
        for (int pass = 0; pass < 2; pass++) begin
            for (int k = 1; k <= 20; k++) begin
                @(negedge clk);
                if (k == 1) bus.enable = (pass == 1);
                bus.step_n = !(k <= 10 || k == 14);
                next_edge();
                if (pass == 0) exp_tick = (k == 3 || k == 16);
                else           exp_tick = (k == 8 || k == 16);
                hb_exp = hb_exp ^ exp_tick;
                n_tests++;
                if (bus.tick !== exp_tick || bus.heartbeat !== hb_exp) begin
                    n_fail++;
                    $display("FAIL step_p%0d_edge%0d: tick=%0b hb=%0b want tick=%0b hb=%0b",
                             pass, k, bus.tick, bus.heartbeat, exp_tick, hb_exp);
                end
            end
            n_tests++;
            if (dut.r_count !== ((pass == 0) ? 5'd7 : 5'd3)) begin
                n_fail++;
                $display("FAIL step_p%0d_count: count=%0d want %0d",
                         pass, dut.r_count, (pass == 0) ? 7 : 3);
            end
        end
    endtask

    task automatic test_reset_mid_count;
        n_tests++;
        if (dut.r_count !== 5'd3) begin
            n_fail++; $display("FAIL midreset_pre_count: count=%0d want 3", dut.r_count);
        end
        test_rate01("midreset");
    endtask

    task automatic test_step_on_rate_change;
        @(negedge clk);
        bus.enable = 1'b0;
        bus.step_n = 1'b0;
        for (int k = 1; k <= 6; k++) begin
            next_edge();
            n_tests++;
            if (bus.tick !== 1'b0) begin
                n_fail++; $display("FAIL stepsel_edge%0d: tick=%0b want 0", k, bus.tick);
            end
            if (k >= 3) begin
                n_tests++;
                if (dut.r_count !== 5'd15) begin
                    n_fail++;
                    $display("FAIL stepsel_count%0d: count=%0d want 15", k, dut.r_count);
                end
            end
            @(negedge clk);
            bus.step_n = 1'b1;
            if (k == 2) bus.sel = 2'b11;
        end
    endtask

    initial begin
        n_tests = 0;
        n_fail  = 0;
        test_reset();
        test_rate01("rate01");
        test_rate_change();
        test_hold_resume();
        test_single_step();
        test_reset_mid_count();
        test_step_on_rate_change();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/tick_generator.md
# tick_generator

Upstream timing stage for the 8-bit display counter: turns the 50 MHz board clock into a single-cycle `tick` strobe that drives the counter's `enable`. The strobe can run at full clock rate or at 1 Hz, 0.5 Hz or 0.25 Hz, and can be paused. While paused, the operator single-steps it with a push button. A `heartbeat` output toggles on every tick for an LED.

## Interface
- `CLK_HZ`, default 50_000_000: clock cycles per second; sets the base period.
- `CW`, default 28: down-counter width. Must satisfy 2^CW > 4*CLK_HZ.

- `clk`  in  1  system clock; all state on the rising edge.
- `clr`  in  1  reset, asynchronous, active-low. Clears all state immediately while low.
- `enable`  in  1  1 = RUN (periodic ticks), 0 = HOLD (ticks only from step).
- `sel`  in  2  rate select, quasi-static switch input.
- `step_n`  in  1  raw push button, active-low, unsynchronized.
- `tick`  out  1  registered one-cycle strobe.
- `heartbeat`  out  1  registered; toggles on every tick.

## Operation
- **Period P by `sel`:**
  - 00 → 1
  - 01 → CLK_HZ
  - 10 → 2*CLK_HZ
  - 11 → 4*CLK_HZ
  - P-1 computed at CW bits; no truncation allowed.
- **State:**
  - `count[CW-1:0]` down-counter.
  - `sel_q[1:0]` registered copy of `sel`.
  - `s1`, `s2`, `s3` button synchronizer/edge chain.
  - `tick`, `heartbeat` output registers.
- **Reset values:**
  - `count` = 0, `sel_q` = 00.
  - `s1` = `s2` = `s3` = 1 (button released).
  - `tick` = 0, `heartbeat` = 0.
- **Button path:** `s1` ← `step_n`, `s2` ← `s1`, `s3` ← `s2`. `press` = `s3` & ~`s2` (falling edge). One press yields exactly one `press` cycle however long the button is held.
- **Per-edge update, highest priority first:**
  1. `sel` ≠ `sel_q`: `sel_q` ← `sel`, `count` ← P(`sel`)-1, `tick` ← 0. Any step or expiry this cycle is discarded.
  2. RUN (`enable` = 1): if `count` = 0, then `tick` ← 1 and `count` ← P(`sel_q`)-1. Otherwise `tick` ← 0 and `count` ← `count`-1. `press` is ignored.
  3. HOLD (`enable` = 0): `count` frozen. `tick` ← `press`.
- **Heartbeat:** `heartbeat` ← `heartbeat` ^ (next value of `tick`). It toggles at the same edge `tick` rises.
- **Boundary cases:**
  - `sel` = 00 in RUN: `count` stays 0 and `tick` is continuously high (every cycle is a tick).
  - RUN→HOLD: `count` keeps its value. On return to RUN, countdown resumes from that value, with no reload and no extra tick.
  - HOLD→RUN with `count` = 0: tick at the first RUN edge.
  - `enable` toggling never by itself produces a tick.
  - `clr` low at any point: outputs go to 0 asynchronously and any in-flight press is lost. After release, the first tick comes per the rules above from `count` = 0.

## Timing
- **RUN, steady `sel`:** `tick` high for exactly 1 cycle out of every P cycles. Spacing between tick rising edges = P cycles exactly.
- **After a `sel` change:**
  - Reload edge: `count` = P-1.
  - First tick: P edges after the reload edge.
  - Spacing between the last old-rate tick and the first new-rate tick: at least P(new)+1 cycles.
- **After `clr` release, RUN, `sel` = 00:** `tick` = 1 after the first rising edge.
- **After `clr` release, RUN, `sel` ≠ 00:**
  - Edge 1 reloads the counter.
  - First tick after edge 1+P.
- **Step latency:** `step_n` sampled low at edge k gives `tick` = 1 after edge k+2, for one cycle.
- **Step spacing:** presses need at least one `step_n`-high sample between them. Each one produces exactly one tick.
- **Counter relationship:** `tick` is registered and glitch-free. The counter sees each tick at its next rising edge, so the counter increments exactly once per tick.

## Test plan
Bench overrides CLK_HZ = 4, CW = 5.
- **Rate 01:** `clr` pulse, `enable` = 1, `sel` = 01.
  - Required: reload at edge 1; ticks after edges 5, 9, 13 (period 4).
  - `heartbeat` reads 1, 0, 1 after each.
- **Rate change:** `sel` 01→11 two cycles after a tick.
  - Required: reload to 15, no tick for 16 cycles, then period 16.
  - Then `sel` → 00: `tick` held high every cycle starting 1 cycle after the reload edge.
- **Hold and resume:** `sel` = 10, drop `enable` with `count` = 5 and hold 20 cycles.
  - Required: `tick` stays 0 and `count` stays 5.
  - Raise `enable`: the tick follows 6 cycles later.
- **Single step:** `enable` = 0, `step_n` low for 10 cycles, high 3, low 1 sample.
  - Required: exactly 2 ticks, each 2 edges after its press is sampled, each 1 cycle wide.
  - The same presses with `enable` = 1 produce no extra ticks.
- **Reset mid-count:** assert `clr` mid-count between edges.
  - Required: `tick`, `heartbeat` and `count` read 0 before the next edge.
  - After release, behaviour matches the first scenario.
- **Step dropped on rate change:** `step_n` press coinciding with a `sel` change in HOLD.
  - Required: no tick, and `count` = P(new)-1.
